// File: rtl/maclaurin_pkg.sv
// Shared types and coefficient table for the Maclaurin-series engine.
// Coefficients are sign + Q1.XW magnitude, rounded to nearest at elaboration.
package maclaurin_pkg;

  typedef enum logic [1:0] {
    MODE_LN1P = 2'd0,
    MODE_EXP  = 2'd1,
    MODE_SIN  = 2'd2,
    MODE_COS  = 2'd3
  } mode_t;

  localparam int TERMS_MAX = 12;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
  } coef_t;

  function automatic coef_t coef(mode_t m, int n, int xw);
    coef_t  c;
    longint f;
    longint d;
    logic   z;
    c = '0;
    f = 1;
    d = 1;
    z = 1'b0;
    if (n < 1 || n > TERMS_MAX) return c;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    case (m)
      MODE_LN1P: begin
        d      = longint'(n);
        c.sign = (n % 2 == 0);
      end
      MODE_EXP: d = f;
      MODE_SIN: begin
        if (n % 2 == 1) begin
          d      = f;
          c.sign = (((n - 1) / 2) % 2 == 1);
        end else z = 1'b1;
      end
      default: begin
        if (n % 2 == 0) begin
          d      = f;
          c.sign = ((n / 2) % 2 == 1);
        end else z = 1'b1;
      end
    endcase
    if (!z) c.mag = 32'(((longint'(1) << xw) + d / 2) / d);
    return c;
  endfunction

  function automatic logic c0(mode_t m);
    return (m == MODE_EXP) || (m == MODE_COS);
  endfunction

endpackage

// File: rtl/maclaurin_coef_rom.sv
// Combinational coefficient lookup by (function, term index); the table is
// elaborated from the package function, entries outside 1..TERMS_MAX are zero.
module maclaurin_coef_rom
  import maclaurin_pkg::*;
#(
  parameter int XW = 16
) (
  input  mode_t       mr,
  input  logic [3:0]  n,
  output logic        csign,
  output logic [XW:0] cmag
);

  logic        sgn_tab [4][16];
  logic [XW:0] mag_tab [4][16];

  for (genvar m = 0; m < 4; m++) begin : g_mode
    for (genvar k = 0; k < 16; k++) begin : g_term
      localparam coef_t C = coef(mode_t'(m), k, XW);
      assign sgn_tab[m][k] = C.sign;
      assign mag_tab[m][k] = C.mag[XW:0];
    end
  end

  assign csign = sgn_tab[mr][n];
  assign cmag  = mag_tab[mr][n];

endmodule

// File: rtl/maclaurin_engine.sv
// Iterative Maclaurin evaluator for ln(1+x), e^x, sin x, cos x; latency 2*TERMS
// cycles, starts are ignored while busy, one shared XW x (XW+1) multiplier.
module maclaurin_engine
  import maclaurin_pkg::*;
#(
  parameter int XW    = 16,
  parameter int RW    = XW + 2,
  parameter int TERMS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] xBus,
  output logic [RW-1:0] rBus,
  output logic          busy,
  output logic          done
);

  localparam int AW = RW + 2;
  localparam logic signed [AW-1:0] ONE = {{(AW-XW-1){1'b0}}, 1'b1, {XW{1'b0}}};

  typedef enum logic [1:0] {IDLE, TERM, POW, FIN} state_t;

  state_t                state;
  mode_t                 mr;
  logic [XW-1:0]         xr;
  logic [XW-1:0]         pw;
  logic signed [AW-1:0]  acc;
  logic [3:0]            n;

  logic                  csign;
  logic [XW:0]           cmag;
  logic [XW:0]           mul_b;
  logic [2*XW:0]         mul_p;
  logic [XW:0]           mul_q;
  logic signed [AW-1:0]  term;

  maclaurin_coef_rom #(.XW(XW)) u_rom (
    .mr    (mr),
    .n     (n),
    .csign (csign),
    .cmag  (cmag)
  );

  // TERM multiplies the power by |c_n|; POW multiplies it by x again.
  assign mul_b = (state == TERM) ? cmag : {1'b0, xr};
  assign mul_p = pw * mul_b;
  assign mul_q = mul_p[2*XW:XW];
  assign term  = signed'({{(AW-XW-1){1'b0}}, mul_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mr    <= MODE_LN1P;
      xr    <= '0;
      pw    <= '0;
      acc   <= '0;
      n     <= '0;
      rBus  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= xBus;
            mr    <= mode_t'(mode);
            pw    <= xBus;
            acc   <= c0(mode_t'(mode)) ? ONE : '0;
            n     <= 4'd1;
            busy  <= 1'b1;
            state <= TERM;
          end
        end
        TERM: begin
          acc   <= csign ? acc - term : acc + term;
          state <= (n == 4'(TERMS)) ? FIN : POW;
        end
        POW: begin
          pw    <= mul_q[XW-1:0];
          n     <= n + 4'd1;
          state <= TERM;
        end
        default: begin
          if (acc[AW-1])          rBus <= '0;
          else if (|acc[AW-2:RW]) rBus <= '1;
          else                    rBus <= acc[RW-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maclaurin_engine.sv
// Directed bench for maclaurin_engine at XW=16, TERMS=8; expected results are
// hand-computed function values in Q2.16 with small truncation tolerances.
module tb_maclaurin_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] xBus;
  logic [17:0] rBus;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  maclaurin_engine #(.XW(16), .RW(18), .TERMS(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .xBus  (xBus),
    .rBus  (rBus),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input longint obs, input longint exp_v,
                       input longint tol = 0);
    n_cmp++;
    if (obs < exp_v - tol || obs > exp_v + tol) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (+/-%0d)", tag, obs, exp_v, tol);
    end
  endtask

  // Returns at the negedge of the cycle following the accepting edge.
  task automatic launch(input logic [1:0] m, input logic [15:0] x);
    @(negedge clk);
    mode  = m;
    xBus  = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'd0;
    xBus  = 16'h5555;
  endtask

  // Waits (bounded) for done; returns at the negedge of the done cycle.
  task automatic collect(output logic [17:0] r, output int lat, output int bcnt,
                         output logic busy_at_done);
    r = '0;
    lat = -1;
    bcnt = 0;
    busy_at_done = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        lat = c;
        r = rBus;
        busy_at_done = busy;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic [15:0] x,
                     input longint exp_v, input longint tol);
    logic [17:0] r;
    int lat, bcnt;
    logic bd;
    launch(m, x);
    collect(r, lat, bcnt, bd);
    check({tag, "_r"}, r, exp_v, tol);
    check({tag, "_lat"}, lat, 16);
  endtask

  initial begin
    logic [17:0] r;
    int lat, bcnt, ndone;
    logic bd;

    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    xBus = '0;
    repeat (3) @(negedge clk);
    check("rst_rbus", rBus, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // ln(1.25) with busy-window checks
    launch(2'd0, 16'h4000);
    collect(r, lat, bcnt, bd);
    check("ln125_r", r, 18'h03920, 4);
    check("ln125_lat", lat, 16);
    check("ln125_busycnt", bcnt, 16);
    check("ln125_busy_at_done", bd, 0);
    @(negedge clk);
    check("ln125_done_single", done, 0);

    run("exp025", 2'd1, 16'h4000, 18'h148B5, 4);
    run("exp0", 2'd1, 16'h0000, 18'h10000, 0);
    run("sin05", 2'd2, 16'h8000, 18'h07ABC, 4);
    run("cos05", 2'd3, 16'h8000, 18'h0E0A9, 4);
    run("exp1", 2'd1, 16'hFFFF, 18'h2B7D9, 8);
    run("ln0", 2'd0, 16'h0000, 18'h00000, 0);

    // Starts during busy are ignored
    launch(2'd2, 16'h8000);
    ndone = 0;
    r = '0;
    for (int c = 0; c < 40; c++) begin
      start = (c == 3 || c == 9);
      mode  = 2'd1;
      xBus  = 16'hFFFF;
      if (done) begin
        ndone++;
        r = rBus;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore_ndone", ndone, 1);
    check("ignore_r", r, 18'h07ABC, 4);

    // Start during the done cycle is accepted
    launch(2'd0, 16'h4000);
    collect(r, lat, bcnt, bd);
    check("b2b_first_r", r, 18'h03920, 4);
    mode  = 2'd3;
    xBus  = 16'h8000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(r, lat, bcnt, bd);
    check("b2b_second_r", r, 18'h0E0A9, 4);
    check("b2b_second_lat", lat, 16);

    // Reset mid-computation
    launch(2'd1, 16'h4000);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rbus", rBus, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_nodone", ndone, 0);
    run("postrst_ln125", 2'd0, 16'h4000, 18'h03920, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
